// File: rtl/vc_input_buffer_if.sv
// vc_input_buffer_if
//   Flit-level port bundle of one router input-port VC buffer.
//   Upstream side : ivalid, ivch, ihead, itail, idata (flit in)
//   Downstream side: oready (in), ovalid, oen, ovch, odata (flit out)
//   Status side   : ocredit (per-VC credit pulse), oerr (sticky error)
//   slave  modport - the buffer's view
//   master modport - the surrounding router / test environment view
interface vc_input_buffer_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  ivalid;
   logic [1:0]            ivch;
   logic                  ihead;
   logic                  itail;
   logic [DATA_WIDTH-1:0] idata;
   logic                  oready;
   logic                  ovalid;
   logic                  oen;
   logic [1:0]            ovch;
   logic [DATA_WIDTH-1:0] odata;
   logic [3:0]            ocredit;
   logic                  oerr;

   modport slave (
      input  ivalid, ivch, ihead, itail, idata, oready,
      output ovalid, oen, ovch, odata, ocredit, oerr
   );

   modport master (
      output ivalid, ivch, ihead, itail, idata, oready,
      input  ovalid, oen, ovch, odata, ocredit, oerr
   );
endinterface

// File: rtl/vc_input_buffer.sv
// vc_input_buffer
//   Per-input-port virtual-channel flit buffer. Four VC FIFOs of DEPTH
//   entries {head, tail, data}; forwards one whole packet at a time
//   (head..tail) to route computation, raising oen on the head flit, and
//   returns a one-cycle credit pulse per freed entry.
//   clk   - single clock, all state on posedge
//   reset - synchronous, active-low
//   bus   - vc_input_buffer_if.slave: flit in, flit out, credits, error
module vc_input_buffer #(
   parameter int DEPTH      = 4,
   parameter int DATA_WIDTH = 8
) (
   input logic              clk,
   input logic              reset,
   vc_input_buffer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = DATA_WIDTH + 2;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   logic [EW-1:0]         mem [4][DEPTH];
   logic [AW-1:0]         wptr [4];
   logic [AW-1:0]         rptr [4];
   logic [CW-1:0]         cnt [4];
   logic [0:0]            state;
   logic [1:0]            lock_vc;
   logic [1:0]            rr;
   logic [3:0]            ocredit_q;
   logic                  oerr_q;
   logic [1:0]            ovch_q;
   logic [DATA_WIDTH-1:0] odata_q;

   logic [3:0]            nonempty;
   logic [3:0]            fhead;
   logic [3:0]            ftail;
   logic [DATA_WIDTH-1:0] fdata [4];
   logic                  sel_valid;
   logic [1:0]            sel_vc;
   logic                  deq;
   logic [1:0]            deq_vc;
   logic                  discard;
   logic                  found;
   logic [1:0]            idx;
   logic                  full;
   logic                  accept;
   logic                  drop;
   logic [3:0]            enq_v;
   logic [3:0]            deq_v;

   // Front-of-FIFO view of every VC (show-ahead).
   always_comb begin
      for (int unsigned v = 0; v < 4; v++) begin
         nonempty[v] = (cnt[v] != '0);
         {fhead[v], ftail[v], fdata[v]} = mem[v][rptr[v]];
      end
   end

   // Output selection: round-robin among head-fronted VCs in IDLE,
   // otherwise the locked VC. A headless front in IDLE is discarded only
   // when nothing is eligible, lowest VC first.
   always_comb begin
      sel_valid = 1'b0;
      sel_vc    = lock_vc;
      deq       = 1'b0;
      deq_vc    = lock_vc;
      discard   = 1'b0;
      found     = 1'b0;
      idx       = '0;
      if (state == ST_IDLE) begin
         for (int unsigned k = 0; k < 4; k++) begin
            idx = rr + 2'(k);
            if (!found && nonempty[idx] && fhead[idx]) begin
               found  = 1'b1;
               sel_vc = idx;
            end
         end
         if (found) begin
            sel_valid = 1'b1;
            deq       = bus.oready;
            deq_vc    = sel_vc;
         end else begin
            // scan high-to-low so the lowest offending VC wins
            for (int unsigned k = 0; k < 4; k++) begin
               if (nonempty[3-k] && !fhead[3-k]) begin
                  discard = 1'b1;
                  deq     = 1'b1;
                  deq_vc  = 2'(3 - k);
               end
            end
         end
      end else begin
         sel_valid = nonempty[lock_vc];
         deq       = nonempty[lock_vc] & bus.oready;
      end
   end

   // A full FIFO still accepts a write when it is drained the same cycle.
   always_comb begin
      full   = (cnt[bus.ivch] == CW'(DEPTH));
      accept = bus.ivalid & (~full | (deq & (deq_vc == bus.ivch)));
      drop   = bus.ivalid & ~accept;
      enq_v  = accept ? (4'b0001 << bus.ivch) : 4'b0000;
      deq_v  = deq    ? (4'b0001 << deq_vc)   : 4'b0000;
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         mem[bus.ivch][wptr[bus.ivch]] <= {bus.ihead, bus.itail, bus.idata};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int unsigned v = 0; v < 4; v++) begin
            wptr[v] <= '0;
            rptr[v] <= '0;
            cnt[v]  <= '0;
         end
         state     <= ST_IDLE;
         lock_vc   <= '0;
         rr        <= '0;
         ocredit_q <= '0;
         oerr_q    <= 1'b0;
         ovch_q    <= '0;
         odata_q   <= '0;
      end else begin
         for (int unsigned v = 0; v < 4; v++) begin
            if (enq_v[v]) wptr[v] <= wptr[v] + AW'(1);
            if (deq_v[v]) rptr[v] <= rptr[v] + AW'(1);
            if (enq_v[v] && !deq_v[v]) begin
               cnt[v] <= cnt[v] + CW'(1);
            end else if (deq_v[v] && !enq_v[v]) begin
               cnt[v] <= cnt[v] - CW'(1);
            end
         end
         ocredit_q <= deq_v;
         oerr_q    <= oerr_q | drop | discard |
                      ((state == ST_LOCKED) & deq & fhead[lock_vc]);
         if (sel_valid) begin
            ovch_q  <= sel_vc;
            odata_q <= fdata[sel_vc];
         end
         if (state == ST_IDLE) begin
            if (sel_valid && deq) begin
               rr <= sel_vc + 2'd1;
               if (!ftail[sel_vc]) begin
                  state   <= ST_LOCKED;
                  lock_vc <= sel_vc;
               end
            end
         end else if (deq && ftail[lock_vc]) begin
            state <= ST_IDLE;
         end
      end
   end

   assign bus.ovalid  = sel_valid;
   assign bus.oen     = sel_valid & (state == ST_IDLE);
   assign bus.ovch    = sel_valid ? sel_vc : ovch_q;
   assign bus.odata   = sel_valid ? fdata[sel_vc] : odata_q;
   assign bus.ocredit = ocredit_q;
   assign bus.oerr    = oerr_q;
endmodule

// File: tb/tb_vc_input_buffer.sv
// tb_vc_input_buffer
//   Self-checking bench for vc_input_buffer: directed scenarios followed by
//   random traffic, compared cycle by cycle against a queue-based model.
module tb_vc_input_buffer;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic       head;
      logic       tail;
      logic [7:0] data;
   } flit_t;

   logic clk = 1'b0;
   logic reset;
   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned cyc   = 0;

   vc_input_buffer_if #(.DATA_WIDTH(8)) bus ();

   vc_input_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // reference model state
   flit_t       q [4][$];
   bit          m_locked;
   int unsigned m_lv;
   int unsigned m_rr;
   bit          m_err;
   logic [3:0]  m_credit;
   logic [1:0]  m_last_vch;
   logic [7:0]  m_last_data;
   bit          in_pkt [4];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int v = 0; v < 4; v++) q[v].delete();
      m_locked    = 1'b0;
      m_lv        = 0;
      m_rr        = 0;
      m_err       = 1'b0;
      m_credit    = '0;
      m_last_vch  = '0;
      m_last_data = '0;
   endtask

   // What the buffer should present now, from packet-level rules.
   task automatic model_view(output bit show, output bit hd, output int unsigned vc, output int disc);
      show = 1'b0;
      hd   = 1'b0;
      vc   = 0;
      disc = -1;
      if (!m_locked) begin
         for (int k = 0; k < 4; k++) begin
            int unsigned c;
            c = (m_rr + k) % 4;
            if (!show && q[c].size() > 0 && q[c][0].head) begin
               show = 1'b1;
               hd   = 1'b1;
               vc   = c;
            end
         end
         if (!show) begin
            for (int v = 0; v < 4; v++)
               if (disc < 0 && q[v].size() > 0 && !q[v][0].head) disc = v;
         end
      end else begin
         vc   = m_lv;
         show = (q[m_lv].size() > 0);
      end
   endtask

   task automatic step(input bit rst_n, input bit iv, input logic [1:0] vch,
                       input bit h, input bit t, input logic [7:0] d, input bit ordy);
      bit          show, hd;
      int unsigned vc;
      int          disc;
      logic [1:0]  e_vch;
      logic [7:0]  e_data;
      flit_t       f;
      @(negedge clk);
      cyc++;
      model_view(show, hd, vc, disc);
      e_vch  = m_last_vch;
      e_data = m_last_data;
      if (show) begin
         e_vch  = 2'(vc);
         e_data = q[vc][0].data;
      end
      check_eq("ovalid",  32'(bus.ovalid),  32'(show));
      check_eq("oen",     32'(bus.oen),     32'(hd));
      check_eq("ovch",    32'(bus.ovch),    32'(e_vch));
      check_eq("odata",   32'(bus.odata),   32'(e_data));
      check_eq("ocredit", 32'(bus.ocredit), 32'(m_credit));
      check_eq("oerr",    32'(bus.oerr),    32'(m_err));

      reset      = rst_n;
      bus.ivalid = iv;
      bus.ivch   = vch;
      bus.ihead  = h;
      bus.itail  = t;
      bus.idata  = d;
      bus.oready = ordy;

      if (!rst_n) begin
         model_reset();
      end else begin
         m_credit = '0;
         if (show) begin
            m_last_vch  = e_vch;
            m_last_data = e_data;
         end
         if (show && ordy) begin
            f = q[vc].pop_front();
            m_credit = 4'(1 << vc);
            if (!m_locked) begin
               m_rr = (vc + 1) % 4;
               if (!f.tail) begin
                  m_locked = 1'b1;
                  m_lv     = vc;
               end
            end else begin
               if (f.head) m_err = 1'b1;
               if (f.tail) m_locked = 1'b0;
            end
         end else if (disc >= 0) begin
            f = q[disc].pop_front();
            m_credit = 4'(1 << disc);
            m_err    = 1'b1;
         end
         if (iv) begin
            if (q[vch].size() < DEPTH) begin
               f.head = h;
               f.tail = t;
               f.data = d;
               q[vch].push_back(f);
            end else begin
               m_err = 1'b1;
            end
         end
      end
   endtask

   task automatic send(input logic [1:0] vch, input bit h, input bit t, input logic [7:0] d, input bit ordy);
      step(1'b1, 1'b1, vch, h, t, d, ordy);
   endtask

   task automatic idle(input int n, input bit ordy);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, ordy);
   endtask

   initial begin
      logic [1:0] r_vch;
      bit         r_iv, r_h, r_t;

      reset      = 1'b0;
      bus.ivalid = 1'b0;
      bus.ivch   = '0;
      bus.ihead  = 1'b0;
      bus.itail  = 1'b0;
      bus.idata  = '0;
      bus.oready = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);

      // single-flit packet on VC2
      send(2'd2, 1'b1, 1'b1, 8'hA5, 1'b1);
      idle(3, 1'b1);

      // two 3-flit packets queued on VC0 and VC1, then drained
      send(2'd0, 1'b1, 1'b0, 8'h10, 1'b0);
      send(2'd1, 1'b1, 1'b0, 8'h20, 1'b0);
      send(2'd0, 1'b0, 1'b0, 8'h11, 1'b0);
      send(2'd1, 1'b0, 1'b0, 8'h21, 1'b0);
      send(2'd0, 1'b0, 1'b1, 8'h12, 1'b0);
      send(2'd1, 1'b0, 1'b1, 8'h22, 1'b0);
      idle(8, 1'b1);

      // locked bubble: VC3 packet stalls while VC0 waits
      send(2'd3, 1'b1, 1'b0, 8'h30, 1'b1);
      idle(2, 1'b1);
      send(2'd0, 1'b1, 1'b1, 8'h40, 1'b1);
      idle(2, 1'b1);
      send(2'd3, 1'b0, 1'b0, 8'h31, 1'b1);
      send(2'd3, 1'b0, 1'b1, 8'h32, 1'b1);
      idle(4, 1'b1);

      // overflow on VC1, then full write with same-cycle dequeue
      send(2'd1, 1'b1, 1'b0, 8'h50, 1'b0);
      send(2'd1, 1'b0, 1'b0, 8'h51, 1'b0);
      send(2'd1, 1'b0, 1'b0, 8'h52, 1'b0);
      send(2'd1, 1'b0, 1'b0, 8'h53, 1'b0);
      send(2'd1, 1'b0, 1'b0, 8'h54, 1'b0);
      send(2'd1, 1'b0, 1'b1, 8'h55, 1'b1);
      idle(6, 1'b1);

      // headless first flit on VC2 after reset
      step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0);
      send(2'd2, 1'b0, 1'b0, 8'h77, 1'b0);
      idle(3, 1'b0);

      // backpressure, then reset mid-packet
      send(2'd0, 1'b1, 1'b0, 8'h60, 1'b0);
      send(2'd0, 1'b0, 1'b0, 8'h61, 1'b0);
      send(2'd0, 1'b0, 1'b1, 8'h62, 1'b0);
      idle(5, 1'b0);
      idle(1, 1'b1);
      step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b1);
      idle(3, 1'b1);

      // random traffic
      for (int v = 0; v < 4; v++) in_pkt[v] = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         r_vch = 2'($urandom_range(0, 3));
         r_iv  = ($urandom_range(0, 1) == 1);
         r_h   = in_pkt[r_vch] ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 19) != 0);
         r_t   = ($urandom_range(0, 2) == 0);
         if (i == 1500) begin
            for (int v = 0; v < 4; v++) in_pkt[v] = 1'b0;
            step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b1);
         end else begin
            if (r_iv) in_pkt[r_vch] = !r_t;
            step(1'b1, r_iv, r_vch, r_h, r_t, 8'($urandom), ($urandom_range(0, 3) != 0));
         end
      end
      idle(2, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
